dp_mem_tdp: RTL and testbench

Parametrised true dual-port memory, the successor to the single read/single write `memory` block. Two symmetric ports, A and B, can each read or write on any cycle. Each port has:
- a valid/ready request handshake,
- per-lane byte-enable writes,
- a configurable read latency with an rvalid strobe.

After every reset a hardware sweep clears the array to zero before either port is released. The block sits between the bus-side masters and the shared buffer storage.

---
 rtl/dp_mem_tdp.sv | 193 +++++++++++++++++++
 tb/tb_dp_mem_tdp.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_mem_tdp.sv
// dp_mem_tdp: true dual-port memory with byte-lane writes and a read pipeline.
//
// After every reset an INIT sweep writes zero to each word, one per cycle;
// both ports stay not-ready until the sweep completes. In RUN either port may
// read or write on any cycle.
//
// Ports (x = a | b, identical):
//   clk, rst       rising-edge clock, synchronous active-low reset
//   x_valid        request present
//   x_wr_en        1 = write, 0 = read
//   x_addr         word address (>= MEM_DEPTH: write dropped, read returns 0)
//   x_wr_data      write data
//   x_be           per-lane write enables
//   x_ready        request can be accepted (high only in RUN)
//   x_rdata        read data, held between rvalid pulses
//   x_rvalid       one-cycle strobe per accepted read
//   init_done      clear sweep finished
module dp_mem_tdp #(
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned MEM_WIDTH  = 32,
    parameter int unsigned ADD_WIDTH  = 4,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned NUM_LANES = MEM_WIDTH / LANE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_valid,
    input  logic                 a_wr_en,
    input  logic [ADD_WIDTH-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0] a_wr_data,
    input  logic [NUM_LANES-1:0] a_be,
    output logic                 a_ready,
    output logic [MEM_WIDTH-1:0] a_rdata,
    output logic                 a_rvalid,

    input  logic                 b_valid,
    input  logic                 b_wr_en,
    input  logic [ADD_WIDTH-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0] b_wr_data,
    input  logic [NUM_LANES-1:0] b_be,
    output logic                 b_ready,
    output logic [MEM_WIDTH-1:0] b_rdata,
    output logic                 b_rvalid,

    output logic                 init_done
);

    localparam int unsigned AW1     = ADD_WIDTH + 1;
    localparam int unsigned NPORTS  = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ADD_WIDTH-1:0] ptr_q, ptr_d;
    logic                 ready_q;
    logic                 init_done_q;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    // Per-port views so both ports share one body of logic; index 0 = A, 1 = B.
    logic [NPORTS-1:0]    p_valid;
    logic [NPORTS-1:0]    p_wr_en;
    logic [ADD_WIDTH-1:0] p_addr   [NPORTS];
    logic [MEM_WIDTH-1:0] p_wdata  [NPORTS];
    logic [NUM_LANES-1:0] p_be     [NPORTS];
    logic [NPORTS-1:0]    p_in_range;
    logic [NPORTS-1:0]    p_rd_acc;
    logic [NPORTS-1:0]    p_wr_acc;
    logic [MEM_WIDTH-1:0] p_rd_word [NPORTS];

    // Read pipeline: stage 0 captures at acceptance, output register follows the last stage.
    logic [RD_LATENCY-1:0] pipe_v [NPORTS];
    logic [MEM_WIDTH-1:0]  pipe_d [NPORTS][RD_LATENCY];
    logic [NPORTS-1:0]     rvalid_q;
    logic [MEM_WIDTH-1:0]  rdata_q [NPORTS];

    assign p_valid    = {b_valid, a_valid};
    assign p_wr_en    = {b_wr_en, a_wr_en};
    assign p_addr[0]  = a_addr;
    assign p_addr[1]  = b_addr;
    assign p_wdata[0] = a_wr_data;
    assign p_wdata[1] = b_wr_data;
    assign p_be[0]    = a_be;
    assign p_be[1]    = b_be;

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ready_q     <= (state_d == ST_RUN);
            init_done_q <= (state_d == ST_RUN);
        end
    end

    // Next-state: sweep one word per cycle, then stay in RUN until reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                if (ptr_q == ADD_WIDTH'(MEM_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Request decode and asynchronous array read (pre-write contents).
    always_comb begin
        p_in_range = '0;
        p_rd_acc   = '0;
        p_wr_acc   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            p_rd_word[p]  = '0;
            p_in_range[p] = ({1'b0, p_addr[p]} < AW1'(MEM_DEPTH));
            p_rd_acc[p]   = p_valid[p] && ready_q && !p_wr_en[p];
            p_wr_acc[p]   = p_valid[p] && ready_q && p_wr_en[p] && p_in_range[p];
            if (p_in_range[p]) begin
                p_rd_word[p] = mem[p_addr[p]];
            end
        end
    end

    // Array writes. B is applied before A so A's enabled lanes win a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_INIT) begin
                mem[ptr_q] <= '0;
            end
            for (int p = NPORTS - 1; p >= 0; p--) begin
                if (p_wr_acc[p]) begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (p_be[p][l]) begin
                            mem[p_addr[p]][l*LANE_WIDTH +: LANE_WIDTH] <=
                                p_wdata[p][l*LANE_WIDTH +: LANE_WIDTH];
                        end
                    end
                end
            end
        end
    end

    // Read pipeline; reset flushes in-flight reads. rdata only moves on a valid beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_q <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                pipe_v[p]  <= '0;
                rdata_q[p] <= '0;
                for (int s = 0; s < RD_LATENCY; s++) begin
                    pipe_d[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                pipe_v[p][0] <= p_rd_acc[p];
                pipe_d[p][0] <= p_rd_word[p];
                for (int s = 1; s < RD_LATENCY; s++) begin
                    pipe_v[p][s] <= pipe_v[p][s-1];
                    pipe_d[p][s] <= pipe_d[p][s-1];
                end
                rvalid_q[p] <= pipe_v[p][RD_LATENCY-1];
                if (pipe_v[p][RD_LATENCY-1]) begin
                    rdata_q[p] <= pipe_d[p][RD_LATENCY-1];
                end
            end
        end
    end

    assign a_ready   = ready_q;
    assign b_ready   = ready_q;
    assign a_rdata   = rdata_q[0];
    assign b_rdata   = rdata_q[1];
    assign a_rvalid  = rvalid_q[0];
    assign b_rvalid  = rvalid_q[1];
    assign init_done = init_done_q;

endmodule

// File: tb/tb_dp_mem_tdp.sv
// Self-checking bench for dp_mem_tdp: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a behavioural model.
module tb_dp_mem_tdp;

    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_wr_en, b_valid, b_wr_en;
    logic [AW-1:0] a_addr, b_addr;
    logic [31:0] a_wr_data, b_wr_data;
    logic [3:0]  a_be, b_be;
    logic        a_ready, b_ready, a_rvalid, b_rvalid, init_done;
    logic [31:0] a_rdata, b_rdata;

    dp_mem_tdp #(
        .MEM_DEPTH (DEPTH),
        .MEM_WIDTH (32),
        .ADD_WIDTH (AW),
        .LANE_WIDTH(8),
        .RD_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_wr_en  (a_wr_en),
        .a_addr   (a_addr),
        .a_wr_data(a_wr_data),
        .a_be     (a_be),
        .a_ready  (a_ready),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_valid  (b_valid),
        .b_wr_en  (b_wr_en),
        .b_addr   (b_addr),
        .b_wr_data(b_wr_data),
        .b_be     (b_be),
        .b_ready  (b_ready),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int          due;
        logic [31:0] d;
    } rd_t;

    logic [31:0] m [DEPTH];
    rd_t         qa[$];
    rd_t         qb[$];
    logic [31:0] last_a, last_b;
    int          edge_n    = 0;
    int          since_rst = 0;
    int          vectors   = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // One clock edge: update the model from the inputs presented, then check all outputs.
    task automatic tick();
        rd_t  r;
        logic exp_rdy, exp_av, exp_bv;
        @(posedge clk);
        edge_n++;
        if (!rst) begin
            since_rst = 0;
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
            for (int i = 0; i < DEPTH; i++) m[i] = '0;
        end else begin
            if (since_rst >= DEPTH) begin
                if (a_valid && !a_wr_en) begin
                    r.due = edge_n + LAT;
                    r.d   = (32'(a_addr) < DEPTH) ? m[a_addr] : 32'h0;
                    qa.push_back(r);
                end
                if (b_valid && !b_wr_en) begin
                    r.due = edge_n + LAT;
                    r.d   = (32'(b_addr) < DEPTH) ? m[b_addr] : 32'h0;
                    qb.push_back(r);
                end
                // Port A has priority on shared lanes, so its lanes are written last.
                if (b_valid && b_wr_en && 32'(b_addr) < DEPTH)
                    for (int l = 0; l < 4; l++)
                        if (b_be[l]) m[b_addr][l*8 +: 8] = b_wr_data[l*8 +: 8];
                if (a_valid && a_wr_en && 32'(a_addr) < DEPTH)
                    for (int l = 0; l < 4; l++)
                        if (a_be[l]) m[a_addr][l*8 +: 8] = a_wr_data[l*8 +: 8];
            end
            since_rst++;
        end
        #1;
        exp_rdy = rst && (since_rst >= DEPTH);
        exp_av  = 1'b0;
        exp_bv  = 1'b0;
        if (qa.size() > 0 && qa[0].due == edge_n) begin
            r = qa.pop_front();
            last_a = r.d;
            exp_av = 1'b1;
        end
        if (qb.size() > 0 && qb[0].due == edge_n) begin
            r = qb.pop_front();
            last_b = r.d;
            exp_bv = 1'b1;
        end
        chk("a_ready",   32'(a_ready),   32'(exp_rdy));
        chk("b_ready",   32'(b_ready),   32'(exp_rdy));
        chk("init_done", 32'(init_done), 32'(exp_rdy));
        chk("a_rvalid",  32'(a_rvalid),  32'(exp_av));
        chk("b_rvalid",  32'(b_rvalid),  32'(exp_bv));
        chk("a_rdata",   a_rdata,        last_a);
        chk("b_rdata",   b_rdata,        last_b);
    endtask

    task automatic idle();
        a_valid = 1'b0; a_wr_en = 1'b0; a_addr = '0; a_wr_data = '0; a_be = '0;
        b_valid = 1'b0; b_wr_en = 1'b0; b_addr = '0; b_wr_data = '0; b_be = '0;
    endtask

    // Count edges from release of reset until ready rises; bounded.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!a_ready && n < 4 * DEPTH) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(DEPTH));
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            a_valid = 1'b1; a_addr = AW'(i);
            b_valid = 1'b1; b_addr = AW'(DEPTH - 1 - i);
            tick();
        end
        idle();
        repeat (LAT) tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        av, aw;
        logic [AW-1:0] aa;
        logic [31:0] ad;
        logic [3:0]  abe;
        logic        bv, bw;
        logic [AW-1:0] ba;
        logic [31:0] bd;
        logic [3:0]  bbe;
        logic        ca;
        logic [31:0] ea;
        logic        cb;
        logic [31:0] eb;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    function automatic vec_t mk(
        input logic av, input logic aw, input logic [AW-1:0] aa, input logic [31:0] ad, input logic [3:0] abe,
        input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [31:0] bd, input logic [3:0] bbe,
        input logic ca, input logic [31:0] ea, input logic cb, input logic [31:0] eb);
        vec_t v;
        v.av = av; v.aw = aw; v.aa = aa; v.ad = ad; v.abe = abe;
        v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd; v.bbe = bbe;
        v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb;
        return v;
    endfunction

    logic [7:0]  rv_seen;
    logic [31:0] exp_d;

    initial begin
        vt[0]  = mk(1,1,4'd3, 32'hAABBCCDD,4'hF, 0,0,4'd0,32'h0,4'h0,        0,32'h0,        0,32'h0);
        vt[1]  = mk(1,1,4'd3, 32'h11223344,4'h5, 0,0,4'd0,32'h0,4'h0,        0,32'h0,        0,32'h0);
        vt[2]  = mk(0,0,4'd0, 32'h0,4'h0,        1,0,4'd3,32'h0,4'h0,        0,32'h0,        1,32'hAA22CC44);
        vt[3]  = mk(1,1,4'd5, 32'h11111111,4'h3, 1,1,4'd5,32'h22222222,4'hF, 0,32'h0,        0,32'h0);
        vt[4]  = mk(1,0,4'd5, 32'h0,4'h0,        0,0,4'd0,32'h0,4'h0,        1,32'h22221111, 0,32'h0);
        vt[5]  = mk(1,1,4'd7, 32'h00000007,4'hF, 0,0,4'd0,32'h0,4'h0,        0,32'h0,        0,32'h0);
        vt[6]  = mk(1,1,4'd7, 32'hDEADBEEF,4'hF, 1,0,4'd7,32'h0,4'h0,        0,32'h0,        1,32'h00000007);
        vt[7]  = mk(1,0,4'd7, 32'h0,4'h0,        0,0,4'd0,32'h0,4'h0,        1,32'hDEADBEEF, 0,32'h0);
        vt[8]  = mk(1,0,4'd12,32'h0,4'h0,        0,0,4'd0,32'h0,4'h0,        1,32'h0,        0,32'h0);
        vt[9]  = mk(1,1,4'd11,32'hCAFEF00D,4'hF, 1,1,4'd12,32'hFFFFFFFF,4'hF,0,32'h0,        0,32'h0);
        vt[10] = mk(0,0,4'd0, 32'h0,4'h0,        1,0,4'd11,32'h0,4'h0,       0,32'h0,        1,32'hCAFEF00D);
        vt[11] = mk(1,1,4'd14,32'h12345678,4'hF, 1,0,4'd0,32'h0,4'h0,        0,32'h0,        1,32'h0);
        vt[12] = mk(1,0,4'd3, 32'h0,4'h0,        1,0,4'd3,32'h0,4'h0,        1,32'hAA22CC44, 1,32'hAA22CC44);
        vt[13] = mk(1,1,4'd5, 32'h0000FF00,4'h2, 1,1,4'd5,32'h99999999,4'h6, 0,32'h0,        0,32'h0);

        // Reset held 3 cycles, partial sweep, reset again mid-INIT, then full sweep.
        idle();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wait_ready("init_edges");
        read_all();

        // Table: each vector alone, result checked LAT edges after acceptance.
        for (int i = 0; i < NV; i++) begin
            idle();
            a_valid = vt[i].av; a_wr_en = vt[i].aw; a_addr = vt[i].aa; a_wr_data = vt[i].ad; a_be = vt[i].abe;
            b_valid = vt[i].bv; b_wr_en = vt[i].bw; b_addr = vt[i].ba; b_wr_data = vt[i].bd; b_be = vt[i].bbe;
            tick();
            idle();
            repeat (LAT) tick();
            chk($sformatf("vec%0d_a_rvalid", i), 32'(a_rvalid), 32'(vt[i].ca));
            chk($sformatf("vec%0d_b_rvalid", i), 32'(b_rvalid), 32'(vt[i].cb));
            if (vt[i].ca) chk($sformatf("vec%0d_a_rdata", i), a_rdata, vt[i].ea);
            if (vt[i].cb) chk($sformatf("vec%0d_b_rdata", i), b_rdata, vt[i].eb);
        end
        read_all();

        // Same-cycle read sees old data; read on the next cycle sees the write.
        for (int k = 0; k <= LAT + 1; k++) begin
            idle();
            if (k == 0) begin
                a_valid = 1'b1; a_wr_en = 1'b1; a_addr = 4'd7; a_wr_data = 32'h0BADF00D; a_be = 4'hF;
                b_valid = 1'b1; b_addr = 4'd7;
            end else if (k == 1) begin
                a_valid = 1'b1; a_addr = 4'd7;
            end
            tick();
            if (k == LAT) chk("rbw_b_old", b_rdata, 32'hDEADBEEF);
            if (k == LAT + 1) chk("raw_a_new", a_rdata, 32'h0BADF00D);
        end

        // Streaming reads across the top of the array.
        idle();
        a_valid = 1'b1; a_wr_en = 1'b1; a_addr = 4'd10; a_wr_data = 32'hA0A0A0A0; a_be = 4'hF;
        b_valid = 1'b1; b_wr_en = 1'b1; b_addr = 4'd11; b_wr_data = 32'hB1B1B1B1; b_be = 4'hF;
        tick();
        rv_seen = '0;
        for (int k = 0; k < LAT + 5; k++) begin
            idle();
            if (k < 4) begin
                a_valid = 1'b1; a_addr = AW'(10 + k);
            end
            tick();
            rv_seen[k] = a_rvalid;
            if (k >= LAT && k < LAT + 4) begin
                case (k - LAT)
                    0:       exp_d = 32'hA0A0A0A0;
                    1:       exp_d = 32'hB1B1B1B1;
                    default: exp_d = 32'h0;
                endcase
                chk($sformatf("stream_rdata_%0d", 10 + k - LAT), a_rdata, exp_d);
            end
        end
        for (int k = 0; k < LAT + 5; k++)
            chk($sformatf("stream_rvalid_k%0d", k), 32'(rv_seen[k]), 32'((k >= LAT) && (k < LAT + 4)));
        idle();
        a_valid = 1'b1; a_wr_en = 1'b1; a_addr = 4'd14; a_wr_data = 32'h5A5A5A5A; a_be = 4'hF;
        tick();
        read_all();

        // Random traffic, with frequent address collisions between ports.
        for (int n = 0; n < 400; n++) begin
            idle();
            a_valid   = ($urandom_range(0, 3) != 0);
            a_wr_en   = 1'($urandom_range(0, 1));
            a_addr    = AW'($urandom_range(0, 15));
            a_wr_data = $urandom;
            a_be      = 4'($urandom_range(0, 15));
            b_valid   = ($urandom_range(0, 3) != 0);
            b_wr_en   = 1'($urandom_range(0, 1));
            b_addr    = ($urandom_range(0, 1) != 0) ? a_addr : AW'($urandom_range(0, 15));
            b_wr_data = $urandom;
            b_be      = 4'($urandom_range(0, 15));
            tick();
        end
        idle();
        repeat (LAT) tick();
        read_all();

        // Reset while a read is in flight: no rvalid, full re-sweep, array cleared.
        idle();
        a_valid = 1'b1; a_wr_en = 1'b1; a_addr = 4'd3; a_wr_data = 32'h55AA55AA; a_be = 4'hF;
        tick();
        idle();
        a_valid = 1'b1; a_addr = 4'd3;
        tick();
        idle();
        rst = 1'b0;
        tick();
        chk("midrst_no_rvalid", 32'(a_rvalid), 32'h0);
        rst = 1'b1;
        wait_ready("midrst_init_edges");
        idle();
        a_valid = 1'b1; a_addr = 4'd3;
        tick();
        idle();
        repeat (LAT) tick();
        chk("midrst_rd3_rvalid", 32'(a_rvalid), 32'h1);
        chk("midrst_rd3_zero",   a_rdata,       32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
